// File: rtl/video_sync_decoder.sv
// Measures video sync timing (line length, sync width, lines per frame), tracks timing lock and
// packs active-region pixels MSB-first into bytes for a capture buffer.
module video_sync_decoder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                  pixel_clk_i,
  input  logic                  reset_n_i,
  input  logic                  h_sync_i,
  input  logic                  v_sync_i,
  input  logic                  h_active_i,
  input  logic                  v_active_i,
  input  logic                  video_i,
  output logic [10:0]           h_total_o,
  output logic [7:0]            h_sync_width_o,
  output logic [9:0]            v_total_o,
  output logic                  locked_o,
  output logic                  frame_start_o,
  output logic [ADDR_WIDTH-1:0] cap_addr_o,
  output logic [7:0]            cap_data_o,
  output logic                  cap_we_o
);

  localparam int unsigned MatchW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {StUnlocked, StMeasure, StLocked} lock_state_e;

  lock_state_e state_q, state_d;

  logic                  hs_q, vs_q, ha_q;
  logic                  hs_rise, hs_fall, vs_rise, ha_fall;
  logic [10:0]           line_cnt_q, line_cnt_d, h_total_q, h_total_d, prev_h_q, prev_h_d;
  logic [7:0]            sw_cnt_q, sw_cnt_d, sw_q, sw_d;
  logic [9:0]            lines_q, lines_d, lines_inc, v_total_q, v_total_d, prev_v_q, prev_v_d;
  logic [MatchW-1:0]     match_q, match_d;
  logic [MatchW:0]       match_inc;
  logic                  line_sat, frame_sat, timing_match;
  logic                  frame_start_q;
  logic [7:0]            shift_q, shift_d, shift_in, wr_byte;
  logic [2:0]            bit_cnt_q, bit_cnt_d, pad;
  logic                  do_write;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, cap_addr_q, cap_addr_d;
  logic [7:0]            cap_data_q, cap_data_d;
  logic                  cap_we_q, cap_we_d;

  assign hs_rise = h_sync_i & ~hs_q;
  assign hs_fall = ~h_sync_i & hs_q;
  assign vs_rise = v_sync_i & ~vs_q;
  assign ha_fall = ~h_active_i & ha_q;

  // Timing measurement
  always_comb begin
    line_sat  = (line_cnt_q == 11'h7ff);
    frame_sat = (lines_q == 10'h3ff);

    line_cnt_d = line_sat ? line_cnt_q : line_cnt_q + 11'd1;
    h_total_d  = h_total_q;
    if (hs_rise) begin
      line_cnt_d = '0;
      if (!line_sat) h_total_d = line_cnt_q + 11'd1;
    end

    sw_cnt_d = '0;
    if (h_sync_i) sw_cnt_d = (sw_cnt_q == 8'hff) ? sw_cnt_q : sw_cnt_q + 8'd1;
    sw_d = hs_fall ? sw_cnt_q : sw_q;

    // A line starting on the v_sync rise cycle still belongs to the closing frame.
    lines_inc = (hs_rise && !frame_sat) ? lines_q + 10'd1 : lines_q;
    lines_d   = lines_inc;
    v_total_d = v_total_q;
    if (vs_rise) begin
      v_total_d = lines_inc;
      lines_d   = '0;
    end
  end

  // Lock tracking, evaluated once per frame against the previous frame's measurements
  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    prev_h_d     = prev_h_q;
    prev_v_d     = prev_v_q;
    timing_match = (h_total_d == prev_h_q) && (v_total_d == prev_v_q);
    match_inc    = {1'b0, match_q} + (MatchW+1)'(1);

    if (line_sat || frame_sat) begin
      state_d = StUnlocked;
      match_d = '0;
    end else if (vs_rise) begin
      case (state_q)
        StUnlocked: begin
          state_d = StMeasure;
          match_d = '0;
        end
        StMeasure: begin
          if (timing_match) begin
            match_d = match_inc[MatchW-1:0];
            if (match_inc >= (MatchW+1)'(LOCK_FRAMES)) state_d = StLocked;
          end else begin
            match_d = '0;
          end
        end
        StLocked: begin
          if (!timing_match) begin
            state_d = StMeasure;
            match_d = '0;
          end
        end
        default: state_d = StUnlocked;
      endcase
    end

    if (vs_rise) begin
      prev_h_d = h_total_d;
      prev_v_d = v_total_d;
    end
  end

  // Pixel capture
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    wr_addr_d  = wr_addr_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    cap_we_d   = 1'b0;
    do_write   = 1'b0;
    wr_byte    = '0;
    shift_in   = {shift_q[6:0], video_i};
    // Left-justify a partial byte: 8 - count, modulo 8, for counts 1..7.
    pad        = 3'd0 - bit_cnt_q;

    if (h_active_i && v_active_i) begin
      shift_d   = shift_in;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        do_write = 1'b1;
        wr_byte  = shift_in;
      end
    end else if (ha_fall && v_active_i && (bit_cnt_q != 3'd0)) begin
      do_write  = 1'b1;
      wr_byte   = shift_q << pad;
      shift_d   = '0;
      bit_cnt_d = '0;
    end

    if (do_write) begin
      cap_we_d   = 1'b1;
      cap_data_d = wr_byte;
      cap_addr_d = wr_addr_q;
      wr_addr_d  = wr_addr_q + ADDR_WIDTH'(1);
    end

    // A write landing on the frame boundary still uses the old address.
    if (vs_rise) begin
      wr_addr_d = '0;
      shift_d   = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge pixel_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      ha_q          <= 1'b0;
      line_cnt_q    <= '0;
      h_total_q     <= '0;
      sw_cnt_q      <= '0;
      sw_q          <= '0;
      lines_q       <= '0;
      v_total_q     <= '0;
      prev_h_q      <= '0;
      prev_v_q      <= '0;
      match_q       <= '0;
      state_q       <= StUnlocked;
      frame_start_q <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      wr_addr_q     <= '0;
      cap_addr_q    <= '0;
      cap_data_q    <= '0;
      cap_we_q      <= 1'b0;
    end else begin
      hs_q          <= h_sync_i;
      vs_q          <= v_sync_i;
      ha_q          <= h_active_i;
      line_cnt_q    <= line_cnt_d;
      h_total_q     <= h_total_d;
      sw_cnt_q      <= sw_cnt_d;
      sw_q          <= sw_d;
      lines_q       <= lines_d;
      v_total_q     <= v_total_d;
      prev_h_q      <= prev_h_d;
      prev_v_q      <= prev_v_d;
      match_q       <= match_d;
      state_q       <= state_d;
      frame_start_q <= vs_rise;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      wr_addr_q     <= wr_addr_d;
      cap_addr_q    <= cap_addr_d;
      cap_data_q    <= cap_data_d;
      cap_we_q      <= cap_we_d;
    end
  end

  assign h_total_o      = h_total_q;
  assign h_sync_width_o = sw_q;
  assign v_total_o      = v_total_q;
  assign locked_o       = (state_q == StLocked);
  assign frame_start_o  = frame_start_q;
  assign cap_addr_o     = cap_addr_q;
  assign cap_data_o     = cap_data_q;
  assign cap_we_o       = cap_we_q;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Drives generated video frames into video_sync_decoder and checks measurements, lock and
// capture writes against a frame-level reference model.
module tb_video_sync_decoder;

  localparam int AW = 3;
  localparam int LF = 2;

  logic          clk = 1'b0;
  logic          reset_n, h_sync, v_sync, h_active, v_active, video;
  logic [10:0]   h_total;
  logic [7:0]    h_sync_width;
  logic [9:0]    v_total;
  logic          locked, frame_start;
  logic [AW-1:0] cap_addr;
  logic [7:0]    cap_data;
  logic          cap_we;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_state;   // 0 unlocked, 1 measuring, 2 locked
  int          m_cnt, m_prev_h, m_prev_v;
  int          m_addr, m_nbits;
  logic [7:0]  m_acc;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  int          cur_len, cur_n, cur_sw;

  video_sync_decoder #(
    .ADDR_WIDTH  (AW),
    .LOCK_FRAMES (LF)
  ) dut (
    .pixel_clk_i    (clk),
    .reset_n_i      (reset_n),
    .h_sync_i       (h_sync),
    .v_sync_i       (v_sync),
    .h_active_i     (h_active),
    .v_active_i     (v_active),
    .video_i        (video),
    .h_total_o      (h_total),
    .h_sync_width_o (h_sync_width),
    .v_total_o      (v_total),
    .locked_o       (locked),
    .frame_start_o  (frame_start),
    .cap_addr_o     (cap_addr),
    .cap_data_o     (cap_data),
    .cap_we_o       (cap_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_h_total"}, 32'(h_total), 0);
    check({tag, "_sync_width"}, 32'(h_sync_width), 0);
    check({tag, "_v_total"}, 32'(v_total), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
    check({tag, "_cap_addr"}, 32'(cap_addr), 0);
    check({tag, "_cap_data"}, 32'(cap_data), 0);
    check({tag, "_cap_we"}, 32'(cap_we), 0);
  endtask

  // Every write strobe must match the oldest expected (address, data) pair.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && cap_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(cap_we), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(cap_addr), 32'(mon_e[15:8]));
        check("wr_data", 32'(cap_data), 32'(mon_e[7:0]));
      end
    end
  end

  task automatic model_reset();
    m_state  = 0;
    m_cnt    = 0;
    m_prev_h = -1;
    m_prev_v = -1;
    m_addr   = 0;
    m_nbits  = 0;
    m_acc    = 8'h00;
    exp_q.delete();
  endtask

  task automatic push_wr(input logic [7:0] b);
    exp_q.push_back({8'(m_addr), b});
    m_addr = (m_addr + 1) % (1 << AW);
  endtask

  task automatic lock_eval(input int h, input int v);
    if (m_state == 0) begin
      m_state = 1;
      m_cnt   = 0;
    end else if (h == m_prev_h && v == m_prev_v) begin
      if (m_state == 1) begin
        m_cnt++;
        if (m_cnt >= LF) m_state = 2;
      end
    end else begin
      m_state = 1;
      m_cnt   = 0;
    end
    m_prev_h = h;
    m_prev_v = v;
  endtask

  task automatic drive(input logic h, input logic v, input logic a, input logic va,
                       input logic d);
    h_sync   = h;
    v_sync   = v;
    h_active = a;
    v_active = va;
    video    = d;
    @(posedge clk);
    #1;
  endtask

  // One line: h_sync for sw clocks, active window of aw pixels starting 4 clocks after sync.
  task automatic send_line(input int len, input int sw, input bit vs_line, input bit act_line,
                           input int aw, input int vmode, input int abort_at,
                           output bit aborted);
    int   a0, p, eh, ev, ew;
    logic a, d;
    aborted = 1'b0;
    a0 = sw + 4;
    for (int c = 0; c < len; c++) begin
      if (c == abort_at) begin
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        aborted = 1'b1;
        return;
      end
      a = (c >= a0) && (c < a0 + aw);
      p = c - a0;
      case (vmode)
        1:       d = a ? logic'(p % 2 == 0) : 1'($urandom);
        2:       d = 1'b1;
        default: d = 1'($urandom);
      endcase
      if (vs_line && c == 0) begin
        eh = cur_len;
        ev = cur_n;
        ew = cur_sw;
        lock_eval(eh, ev);
        m_addr  = 0;
        m_nbits = 0;
        m_acc   = 8'h00;
      end
      if (a && act_line) begin
        m_acc[7 - m_nbits] = d;
        m_nbits++;
        if (m_nbits == 8) begin
          push_wr(m_acc);
          m_nbits = 0;
          m_acc   = 8'h00;
        end
      end else if (act_line && c == a0 + aw && m_nbits > 0) begin
        push_wr(m_acc);
        m_nbits = 0;
        m_acc   = 8'h00;
      end
      drive(logic'(c < sw), vs_line, a, act_line, d);
      if (vs_line && c == 0) begin
        check("frame_start", 32'(frame_start), 1);
        check("h_total", 32'(h_total), 32'(eh));
        check("v_total", 32'(v_total), 32'(ev));
        check("h_sync_width", 32'(h_sync_width), 32'(ew));
        check("locked", 32'(locked), 32'(m_state == 2));
      end
      if (vs_line && c == 1) check("frame_start_pulse", 32'(frame_start), 0);
    end
  endtask

  // Source is picked up mid-frame (line 1 onward) with blanked video, so the first v_sync
  // rise already closes a full-geometry frame.
  task automatic send_preroll(input int len, input int sw, input int n);
    bit ab;
    for (int ln = 1; ln < n; ln++) send_line(len, sw, 1'b0, 1'b0, 0, 0, -1, ab);
    cur_len = len;
    cur_n   = n;
    cur_sw  = sw;
  endtask

  task automatic send_frame(input int len, input int sw, input int n, input int aw,
                            input int al, input int vmode, input int abort_at,
                            output bit aborted);
    for (int ln = 0; ln < n; ln++) begin
      send_line(len, sw, ln == 0, (ln >= 1) && (ln <= al), aw, vmode,
                (ln == 1) ? abort_at : -1, aborted);
      if (aborted) return;
      if (ln == 0) begin
        cur_len = len;
        cur_n   = n;
        cur_sw  = sw;
      end
    end
  endtask

  task automatic frames(input int cnt, input int len, input int sw, input int n,
                        input int aw, input int al, input int vmode);
    bit ab;
    repeat (cnt) send_frame(len, sw, n, aw, al, vmode, -1, ab);
  endtask

  task automatic restart();
    h_sync   = 1'b0;
    v_sync   = 1'b0;
    h_active = 1'b0;
    v_active = 1'b0;
    video    = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit ab;
    reset_n  = 1'b0;
    h_sync   = 1'b0;
    v_sync   = 1'b0;
    h_active = 1'b0;
    v_active = 1'b0;
    video    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    restart();

    // Nominal geometry with alternating pixels, then a one-frame line-length glitch.
    send_preroll(48, 8, 4);
    frames(5, 48, 8, 4, 24, 2, 1);
    frames(1, 50, 8, 4, 24, 2, 1);
    frames(4, 48, 8, 4, 24, 2, 1);

    // Partial bytes, then address wrap with 10 bytes per frame.
    frames(3, 48, 8, 4, 12, 2, 2);
    frames(3, 64, 8, 4, 40, 2, 0);

    // Random geometries and video.
    for (int i = 0; i < 8; i++) begin
      int len, sw, n, awmax, aw, al, reps;
      len   = int'($urandom_range(90, 40));
      sw    = int'($urandom_range(10, 2));
      n     = int'($urandom_range(6, 3));
      awmax = (len - sw - 5 > 30) ? 30 : len - sw - 5;
      aw    = int'($urandom_range(awmax, 1));
      al    = int'($urandom_range(n - 1, 1));
      reps  = int'($urandom_range(3, 1));
      frames(reps, len, sw, n, aw, al, 0);
    end

    // Lock, then starve h_sync until the line counter saturates.
    frames(4, 48, 8, 4, 8, 1, 0);
    check("pre_sat_locked", 32'(locked), 32'(m_state == 2));
    repeat (3000) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
    m_state = 0;
    check("sat_unlocked", 32'(locked), 0);

    // Reset in the middle of a byte, then resume.
    restart();
    send_preroll(48, 8, 4);
    frames(1, 48, 8, 4, 24, 2, 1);
    send_frame(48, 8, 4, 24, 2, 0, 8 + 4 + 3, ab);
    check("abort_reached", 32'(ab), 1);
    restart();
    send_preroll(48, 8, 4);
    frames(4, 48, 8, 4, 20, 2, 0);

    repeat (10) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pending_writes", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
